z_core_mul_ctrl: RTL and testbench

Sequencer for the shared M-extension multiplier in the execute stage. It accepts one MUL/MULH/MULHSU/MULHU request at a time over a valid/ready handshake and derives the multiplier signedness controls from the op code. It holds the operation for a fixed MUL_LAT cycles, then presents the selected 32-bit half over a valid/ready response port. The execute stage stalls on `busy` or on `req_ready` low.

---
 rtl/z_core_mul_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_z_core_mul_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z_core_mul_ctrl.sv
// z_core_mul_ctrl: sequencer for the shared M-extension multiplier.
// Accepts one MUL/MULH/MULHSU/MULHU request over valid/ready, holds it for
// MUL_LAT cycles and returns the selected 32-bit half over valid/ready.
// Optional build macro Z_CORE_MUL_FUSE_EN adds a single-entry product cache
// so a high/low pair on the same operands completes in one cycle.
module z_core_mul_ctrl #(
   parameter int MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [4:0]  req_op,
   input  logic [31:0] req_rs1,
   input  logic [31:0] req_rs2,
   input  logic [4:0]  req_rd,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [4:0]  rsp_rd,
   output logic        busy
);

   localparam logic [4:0] OP_MUL    = 5'd16;
   localparam logic [4:0] OP_MULH   = 5'd17;
   localparam logic [4:0] OP_MULHSU = 5'd18;
   localparam logic [4:0] OP_MULHU  = 5'd19;
   localparam logic [2:0] LAT_M1    = 3'(MUL_LAT - 1);
   localparam logic       LAT_ONE   = (MUL_LAT == 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t      state;
   state_t      next_state;
   logic        busy_q;
   logic [2:0]  cnt_p0;
   logic [4:0]  op_p0;
   logic [31:0] rs1_p0;
   logic [31:0] rs2_p0;
   logic [4:0]  rd_p0;
   logic [31:0] data_p1;
   logic [4:0]  rd_p1;

   logic        accept;
   logic        complete;
   logic        hit;
   logic [31:0] hit_data;
   logic        from_req;
   logic [4:0]  mop;
   logic [31:0] ma;
   logic [31:0] mb;
   logic        ms1;
   logic        ms2;
   logic [63:0] prod;
   logic [31:0] result;

   function automatic logic is_op1_signed(input logic [4:0] op);
      return (op == OP_MULH) || (op == OP_MULHSU);
   endfunction

   function automatic logic is_op2_signed(input logic [4:0] op);
      return (op == OP_MULH);
   endfunction

   // 33x33 signed multiply; the extra top bit carries the signedness choice
   function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                         input logic sa, input logic sb);
      logic signed [32:0] ax;
      logic signed [32:0] bx;
      logic signed [65:0] p;
      ax = $signed({sa & a[31], a});
      bx = $signed({sb & b[31], b});
      p  = ax * bx;
      return p[63:0];
   endfunction

   // Low half for MUL, high half for the MULH family, zero for anything else
   function automatic logic [31:0] select_half(input logic [4:0] op, input logic [63:0] p);
      logic [31:0] r;
      r = 32'd0;
      case (op)
         OP_MUL:                       r = p[31:0];
         OP_MULH, OP_MULHSU, OP_MULHU: r = p[63:32];
         default:                      r = 32'd0;
      endcase
      return r;
   endfunction

   assign req_ready = (state == IDLE) && !flush;
   assign accept    = req_valid && req_ready;
   assign rsp_valid = (state == DONE);
   assign rsp_data  = data_p1;
   assign rsp_rd    = rd_p1;
   assign busy      = busy_q;

   // The multiplier reads the request directly only for a same-edge
   // completion (MUL_LAT==1); otherwise it reads the captured operands.
   assign from_req = (state == IDLE);
   assign mop      = from_req ? req_op  : op_p0;
   assign ma       = from_req ? req_rs1 : rs1_p0;
   assign mb       = from_req ? req_rs2 : rs2_p0;
   assign ms1      = is_op1_signed(mop);
   assign ms2      = is_op2_signed(mop);
   assign prod     = mul64(ma, mb, ms1, ms2);
   assign result   = select_half(mop, prod);

   assign complete = !flush &&
                     (((state == CALC) && (cnt_p0 == 3'd1)) || (accept && LAT_ONE && !hit));

`ifdef Z_CORE_MUL_FUSE_EN
   logic        cache_vld;
   logic [63:0] cache_prod;
   logic [31:0] cache_rs1;
   logic [31:0] cache_rs2;
   logic        cache_s1;
   logic        cache_s2;

   // The low half does not depend on signedness, so MUL hits on operands alone
   assign hit = cache_vld && (req_rs1 == cache_rs1) && (req_rs2 == cache_rs2) &&
                ((req_op == OP_MUL) ||
                 ((is_op1_signed(req_op) == cache_s1) && (is_op2_signed(req_op) == cache_s2)));
   assign hit_data = select_half(req_op, cache_prod);

   // Cache refill on every computed completion; dropped on reset or flush
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         cache_vld  <= 1'b0;
         cache_prod <= 64'd0;
         cache_rs1  <= 32'd0;
         cache_rs2  <= 32'd0;
         cache_s1   <= 1'b0;
         cache_s2   <= 1'b0;
      end else if (complete) begin
         cache_vld  <= 1'b1;
         cache_prod <= prod;
         cache_rs1  <= ma;
         cache_rs2  <= mb;
         cache_s1   <= ms1;
         cache_s2   <= ms2;
      end
   end
`else
   assign hit      = 1'b0;
   assign hit_data = 32'd0;
`endif

   // State register; busy tracks the registered state
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         busy_q <= 1'b0;
      end else begin
         state  <= next_state;
         busy_q <= (next_state != IDLE);
      end
   end

   // Next-state logic; flush forces IDLE from anywhere
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept) begin
               next_state = (LAT_ONE || hit) ? DONE : CALC;
            end
         end
         CALC: begin
            if (cnt_p0 == 3'd1) begin
               next_state = DONE;
            end
         end
         DONE: begin
            if (rsp_ready) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
      if (flush) begin
         next_state = IDLE;
      end
   end

   // ---- p0: request capture and latency counter ----
   // Latency counter: loaded on a computed accept, runs down while in CALC
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         cnt_p0 <= 3'd0;
      end else if (accept && !hit && !LAT_ONE) begin
         cnt_p0 <= LAT_M1;
      end else if (state == CALC) begin
         cnt_p0 <= cnt_p0 - 3'd1;
      end
   end

   // Operand capture so the requester is free to move on after accept
   always_ff @(posedge clk) begin
      if (rst) begin
         op_p0  <= 5'd0;
         rs1_p0 <= 32'd0;
         rs2_p0 <= 32'd0;
         rd_p0  <= 5'd0;
      end else if (accept) begin
         op_p0  <= req_op;
         rs1_p0 <= req_rs1;
         rs2_p0 <= req_rs2;
         rd_p0  <= req_rd;
      end
   end

   // ---- p1: response register ----
   // Response register: loaded on completion, zeroed whenever not valid
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         data_p1 <= 32'd0;
         rd_p1   <= 5'd0;
      end else if (accept && hit) begin
         data_p1 <= hit_data;
         rd_p1   <= req_rd;
      end else if (complete) begin
         data_p1 <= result;
         rd_p1   <= from_req ? req_rd : rd_p0;
      end else if ((state == DONE) && rsp_ready) begin
         data_p1 <= 32'd0;
         rd_p1   <= 5'd0;
      end
   end

endmodule

// File: tb/tb_z_core_mul_ctrl.sv
// Testbench for z_core_mul_ctrl: five instances (MUL_LAT 1,2,3,4,8) share the
// stimulus bus; only the selected instance sees req_valid/rsp_ready.
module tb_z_core_mul_ctrl;

   localparam int N = 5;
   localparam int LATS [N] = '{1, 2, 3, 4, 8};

`ifdef Z_CORE_MUL_FUSE_EN
   localparam bit FUSE = 1'b1;
`else
   localparam bit FUSE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        req_valid;
   logic        rsp_ready;
   logic [4:0]  req_op;
   logic [31:0] req_rs1;
   logic [31:0] req_rs2;
   logic [4:0]  req_rd;
   int          sel;

   logic        req_valid_a [N];
   logic        rsp_ready_a [N];
   logic        req_ready_a [N];
   logic        rsp_valid_a [N];
   logic        busy_a      [N];
   logic [31:0] rsp_data_a  [N];
   logic [4:0]  rsp_rd_a    [N];

   logic        req_ready_s;
   logic        rsp_valid_s;
   logic        busy_s;
   logic [31:0] rsp_data_s;
   logic [4:0]  rsp_rd_s;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      assign req_valid_a[g] = req_valid && (sel == g);
      assign rsp_ready_a[g] = rsp_ready && (sel == g);
      z_core_mul_ctrl #(.MUL_LAT(LATS[g])) u_dut (
         .clk       (clk),
         .rst       (rst),
         .flush     (flush),
         .req_valid (req_valid_a[g]),
         .req_ready (req_ready_a[g]),
         .req_op    (req_op),
         .req_rs1   (req_rs1),
         .req_rs2   (req_rs2),
         .req_rd    (req_rd),
         .rsp_valid (rsp_valid_a[g]),
         .rsp_ready (rsp_ready_a[g]),
         .rsp_data  (rsp_data_a[g]),
         .rsp_rd    (rsp_rd_a[g]),
         .busy      (busy_a[g])
      );
   end

   assign req_ready_s = req_ready_a[sel];
   assign rsp_valid_s = rsp_valid_a[sel];
   assign busy_s      = busy_a[sel];
   assign rsp_data_s  = rsp_data_a[sel];
   assign rsp_rd_s    = rsp_rd_a[sel];

   int checks = 0;
   int errors = 0;

   // Reference model state: latency per instance and cached operand record
   int          lat_of [N];
   bit          m_cvld [N];
   logic [31:0] m_crs1 [N];
   logic [31:0] m_crs2 [N];
   bit          m_cs1  [N];
   bit          m_cs2  [N];

   typedef struct {
      int          inst;
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      int          delay;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Integer-arithmetic product from the op's signedness rules
   function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      longint      x;
      longint      y;
      logic [63:0] p;
      x = (op == 5'd17 || op == 5'd18) ? longint'($signed(a)) : longint'({32'd0, a});
      y = (op == 5'd17) ? longint'($signed(b)) : longint'({32'd0, b});
      p = 64'(x * y);
      if (op == 5'd16) return p[31:0];
      if (op >= 5'd17 && op <= 5'd19) return p[63:32];
      return 32'd0;
   endfunction

   function automatic bit sgn1(input logic [4:0] op);
      return (op == 5'd17) || (op == 5'd18);
   endfunction

   function automatic bit sgn2(input logic [4:0] op);
      return (op == 5'd17);
   endfunction

   task automatic invalidate_model();
      for (int i = 0; i < N; i++) m_cvld[i] = 1'b0;
   endtask

   // One full transaction on instance inst; returns measured latency
   task automatic do_op(input int inst, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int delay,
                        input logic [31:0] exp, output int lat);
      bit          hit;
      int          exp_lat;
      logic [31:0] held;
      hit = FUSE && m_cvld[inst] && (m_crs1[inst] == a) && (m_crs2[inst] == b) &&
            ((op == 5'd16) || ((sgn1(op) == m_cs1[inst]) && (sgn2(op) == m_cs2[inst])));
      exp_lat = hit ? 1 : lat_of[inst];
      lat = -1;
      @(negedge clk);
      sel = inst;
      req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd;
      req_valid = 1'b1;
      rsp_ready = (delay == 0);
      #1;
      chk("req_ready_idle", req_ready_s, 1'b1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_op = 5'($urandom); req_rs1 = $urandom; req_rs2 = $urandom; req_rd = 5'($urandom);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) chk("busy_after_accept", busy_s, 1'b1);
         if (rsp_valid_s) begin
            lat = k;
            break;
         end
      end
      if (lat < 0) begin
         chk("rsp_valid_timeout", 1'b0, 1'b1);
         rsp_ready = 1'b1;
         return;
      end
      chk("latency", 64'(lat), 64'(exp_lat));
      chk("rsp_data", rsp_data_s, exp);
      chk("rsp_rd", rsp_rd_s, rd);
      held = rsp_data_s;
      for (int d = 0; d < delay; d++) begin
         @(negedge clk);
         chk("bp_valid", rsp_valid_s, 1'b1);
         chk("bp_data_stable", rsp_data_s, held);
         chk("bp_req_ready", req_ready_s, 1'b0);
         chk("bp_busy", busy_s, 1'b1);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("idle_valid", rsp_valid_s, 1'b0);
      chk("idle_req_ready", req_ready_s, 1'b1);
      chk("idle_busy", busy_s, 1'b0);
      chk("idle_data_zero", rsp_data_s, 32'd0);
      if (FUSE && !hit) begin
         m_cvld[inst] = 1'b1;
         m_crs1[inst] = a;
         m_crs2[inst] = b;
         m_cs1[inst]  = sgn1(op);
         m_cs2[inst]  = sgn2(op);
      end
   endtask

   initial begin
      int          lat;
      logic [31:0] pool [6];
      for (int i = 0; i < N; i++) lat_of[i] = LATS[i];
      invalidate_model();
      pool = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1234_5678};

      vecs[0] = '{1, 5'd16, 32'd7,          32'd6,          5'd3,  0, 32'd42};
      vecs[1] = '{1, 5'd19, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd4,  0, 32'hFFFF_FFFE};
      vecs[2] = '{1, 5'd17, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd5,  0, 32'h0000_0000};
      vecs[3] = '{1, 5'd18, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd6,  0, 32'hFFFF_FFFF};
      vecs[4] = '{1, 5'd16, 32'h0001_0000,  32'h0001_0000,  5'd7,  5, 32'h0000_0000};
      vecs[5] = '{0, 5'd5,  32'd9,          32'd9,          5'd8,  0, 32'd0};
      vecs[6] = '{4, 5'd5,  32'd9,          32'd11,         5'd9,  1, 32'd0};
      vecs[7] = '{0, 5'd16, 32'd3,          32'd5,          5'd10, 2, 32'd15};
      vecs[8] = '{4, 5'd19, 32'h8000_0000,  32'd4,          5'd11, 0, 32'd2};
      vecs[9] = '{4, 5'd17, 32'h8000_0000,  32'd2,          5'd12, 0, 32'hFFFF_FFFF};

      rst = 1'b1; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      req_op = 5'd0; req_rs1 = 32'd0; req_rs2 = 32'd0; req_rd = 5'd0; sel = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int i = 0; i < N; i++) begin
         chk("rst_req_ready", req_ready_a[i], 1'b1);
         chk("rst_rsp_valid", rsp_valid_a[i], 1'b0);
         chk("rst_rsp_data", rsp_data_a[i], 32'd0);
         chk("rst_rsp_rd", rsp_rd_a[i], 5'd0);
         chk("rst_busy", busy_a[i], 1'b0);
      end

      for (int v = 0; v < 10; v++) begin
         do_op(vecs[v].inst, vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].rd,
               vecs[v].delay, vecs[v].exp, lat);
      end

      // Flush one cycle after accept on MUL_LAT=4, with a request in the flush cycle
      @(negedge clk);
      sel = 3; req_op = 5'd16; req_rs1 = 32'd9; req_rs2 = 32'd9; req_rd = 5'd1;
      req_valid = 1'b1; rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      flush = 1'b1; req_valid = 1'b1; req_op = 5'd19; req_rd = 5'd2;
      #1;
      chk("flush_req_ready", req_ready_s, 1'b0);
      @(posedge clk);
      #1;
      flush = 1'b0; req_valid = 1'b0;
      invalidate_model();
      @(negedge clk);
      chk("post_flush_req_ready", req_ready_s, 1'b1);
      chk("post_flush_busy", busy_s, 1'b0);
      chk("post_flush_valid", rsp_valid_s, 1'b0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("flushed_no_valid", rsp_valid_s, 1'b0);
      end
      do_op(3, 5'd16, 32'd3, 32'd5, 5'd13, 0, 32'd15, lat);
      chk("post_flush_latency4", 64'(lat), 64'd4);

      // Reset in the middle of a MUL_LAT=8 computation
      @(negedge clk);
      sel = 4; req_op = 5'd19; req_rs1 = 32'hDEAD_BEEF; req_rs2 = 32'h1234_5678; req_rd = 5'd21;
      req_valid = 1'b1; rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      invalidate_model();
      chk("midrst_valid", rsp_valid_s, 1'b0);
      chk("midrst_busy", busy_s, 1'b0);
      chk("midrst_data", rsp_data_s, 32'd0);
      chk("midrst_rd", rsp_rd_s, 5'd0);
      chk("midrst_req_ready", req_ready_s, 1'b1);
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         chk("midrst_no_valid", rsp_valid_s, 1'b0);
      end

`ifdef Z_CORE_MUL_FUSE_EN
      // Fused high/low pair on MUL_LAT=3 starting from an empty cache
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      invalidate_model();
      do_op(2, 5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 0, 32'hFFFF_FFFE, lat);
      chk("fuse_mulhu_lat", 64'(lat), 64'd3);
      do_op(2, 5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0, 32'h0000_0001, lat);
      chk("fuse_mul_hit_lat", 64'(lat), 64'd1);
      do_op(2, 5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0, 32'h0000_0000, lat);
      chk("fuse_mulh_miss_lat", 64'(lat), 64'd3);
`endif

      // Randomized traffic against the reference model
      for (int it = 0; it < 150; it++) begin
         int          inst;
         int          r;
         logic [4:0]  op;
         logic [31:0] a;
         logic [31:0] b;
         inst = $urandom_range(0, N - 1);
         r = $urandom_range(0, 5);
         op = (r < 4) ? 5'(16 + r) : ((r == 4) ? 5'($urandom_range(0, 31)) : 5'd16);
         a = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
         b = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
         do_op(inst, op, a, b, 5'($urandom), $urandom_range(0, 2), ref_result(op, a, b), lat);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
